axi_rd_arbiter: RTL and testbench

- Read-side scheduler in front of the AXI master port.
- Accepts SRAM-style read requests from two requesters: instruction fetch (ID 0) and data load (ID 1).
- Arbitrates them onto a single registered AR channel and tracks outstanding reads per ID.
- Routes R beats back to the owning requester by rid. Holds data reads that hit a pending write address (read-after-write hazard).

---
 rtl/axi_rd_arbiter.sv | 94 +++++++++
 tb/tb_axi_rd_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin scheduler of inst/data SRAM-style reads onto one AXI AR channel,
// with per-ID outstanding tracking, R-beat routing and read-after-write hold on data reads.
module axi_rd_arbiter #(
  parameter int MAX_OUTS = 2,
  parameter int ADDR_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [1:0]        inst_size,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [31:0]       inst_rdata,
  input  logic              data_req,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [1:0]        data_size,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       data_rdata,
  input  logic              wr_pend_valid,
  input  logic [ADDR_W-1:0] wr_pend_addr,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [31:0]       rdata,
  input  logic              rvalid,
  output logic              rready,
  output logic              err_rid
);
  typedef enum logic {IDLE, AR_WAIT} state_t;
  state_t state;
  logic [2:0] cnt0, cnt1;
  logic rr, open, hazard, inst_el, data_el, gnt_i, gnt_d, hit0, hit1, unused_ok;
  assign unused_ok = ^wr_pend_addr[1:0];
  assign open = state == IDLE || (state == AR_WAIT && arready);
  // hazard is judged on word address only
  assign hazard = wr_pend_valid && data_addr[ADDR_W-1:2] == wr_pend_addr[ADDR_W-1:2];
  assign inst_el = inst_req && cnt0 < 3'(MAX_OUTS);
  assign data_el = data_req && cnt1 < 3'(MAX_OUTS) && !hazard;
  // rr=0 prefers inst, rr=1 prefers data
  assign gnt_i = open && inst_el && (!data_el || !rr);
  assign gnt_d = open && data_el && (!inst_el || rr);
  assign inst_addr_ok = gnt_i;
  assign data_addr_ok = gnt_d;
  assign hit0 = rvalid && rid == 4'd0 && cnt0 != 3'd0;
  assign hit1 = rvalid && rid == 4'd1 && cnt1 != 3'd0;
  assign inst_data_ok = hit0;
  assign data_data_ok = hit1;
  assign inst_rdata = rdata;
  assign data_rdata = rdata;
  assign arlen = 8'd0;
  assign arburst = 2'b01;
  assign arlock = 2'b00;
  assign arcache = 4'd0;
  assign arprot = 3'd0;
  assign rready = 1'b1;
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= IDLE;
      arvalid <= 1'b0;
      arid <= 4'd0;
      araddr <= '0;
      arsize <= 3'd0;
      cnt0 <= 3'd0;
      cnt1 <= 3'd0;
      rr <= 1'b0;
      err_rid <= 1'b0;
    end else begin
      if (gnt_i || gnt_d) begin
        state <= AR_WAIT;
        arvalid <= 1'b1;
        arid <= gnt_d ? 4'd1 : 4'd0;
        araddr <= gnt_d ? data_addr : inst_addr;
        arsize <= {1'b0, gnt_d ? data_size : inst_size};
        rr <= gnt_i;
      end else if (state == AR_WAIT && arready) begin
        state <= IDLE;
        arvalid <= 1'b0;
      end
      cnt0 <= cnt0 + {2'b0, gnt_i} - {2'b0, hit0};
      cnt1 <= cnt1 + {2'b0, gnt_d} - {2'b0, hit1};
      if (rvalid && !hit0 && !hit1) err_rid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed stimulus with AR/R scoreboards checked by a negedge monitor.
module tb_axi_rd_arbiter;
  logic aclk, aresetn;
  logic inst_req, data_req, wr_pend_valid, arready, rvalid;
  logic [31:0] inst_addr, data_addr, wr_pend_addr, rdata;
  logic [1:0] inst_size, data_size;
  logic [3:0] rid;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, arvalid, rready, err_rid;
  logic [31:0] inst_rdata, data_rdata, araddr;
  logic [3:0] arid, arcache;
  logic [7:0] arlen;
  logic [2:0] arsize, arprot;
  logic [1:0] arburst, arlock;
  int total = 0, bad = 0;
  logic [38:0] ar_q[$];
  logic [32:0] r_q[$];

  axi_rd_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .wr_pend_valid(wr_pend_valid), .wr_pend_addr(wr_pend_addr),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready), .err_rid(err_rid)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic sample;
    @(negedge aclk);
  endtask

  task automatic beat(input logic [3:0] id, input logic [31:0] d);
    rvalid = 1'b1; rid = id; rdata = d;
    r_q.push_back({id[0], d});
    sample;
    tick;
    rvalid = 1'b0;
  endtask

  always @(negedge aclk) if (aresetn) begin
    if (arvalid && arready) begin
      if (ar_q.size() == 0) chk("ar_unexpected", {25'd0, arid, araddr, arsize}, 64'd0);
      else chk("ar_beat", {25'd0, arid, araddr, arsize}, {25'd0, ar_q.pop_front()});
    end
    if (inst_data_ok || data_data_ok) begin
      if (r_q.size() == 0) chk("r_unexpected", {31'd0, data_data_ok, inst_rdata}, 64'd0);
      else chk("r_route", {31'd0, data_data_ok, data_data_ok ? data_rdata : inst_rdata},
               {31'd0, r_q.pop_front()});
    end
  end

  initial begin
    aresetn = 1'b0; inst_req = 0; data_req = 0; wr_pend_valid = 0; arready = 0; rvalid = 0;
    inst_addr = 0; data_addr = 0; wr_pend_addr = 0; rdata = 0; inst_size = 0; data_size = 0; rid = 0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    sample;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_ar", {arid, araddr, arsize}, 0);
    chk("rst_err", err_rid, 0);
    chk("const_ar", {arlen, arburst, arlock, arcache, arprot, rready}, {8'd0, 2'b01, 2'd0, 4'd0, 3'd0, 1'b1});
    tick;
    // single inst read
    inst_req = 1; inst_addr = 32'h1C000000; inst_size = 2;
    sample;
    chk("t1_addr_ok", inst_addr_ok, 1);
    ar_q.push_back({4'd0, 32'h1C000000, 3'd2});
    tick;
    inst_req = 0;
    sample;
    chk("t1_arvalid", {arvalid, arid, araddr, arsize}, {1'b1, 4'd0, 32'h1C000000, 3'd2});
    tick;
    arready = 1;
    sample;
    tick;
    arready = 0;
    sample;
    chk("t1_ar_done", arvalid, 0);
    tick;
    beat(4'd0, 32'hDEADBEEF);
    sample;
    chk("t1_cnt0", dut.cnt0, 0);
    // alternation under contention, after fresh reset
    aresetn = 0;
    tick;
    aresetn = 1; arready = 1;
    inst_req = 1; inst_addr = 32'h1C000040; inst_size = 2;
    data_req = 1; data_addr = 32'h80000000; data_size = 1;
    for (int k = 0; k < 6; k++) begin
      sample;
      chk($sformatf("t2_inst_ok%0d", k), inst_addr_ok, k < 4 && k % 2 == 0);
      chk($sformatf("t2_data_ok%0d", k), data_addr_ok, k < 4 && k % 2 == 1);
      if (k < 4) ar_q.push_back(k % 2 == 0 ? {4'd0, 32'h1C000040, 3'd2} : {4'd1, 32'h80000000, 3'd1});
      if (k >= 4) chk("t2_cnts", {dut.cnt0, dut.cnt1}, {3'd2, 3'd2});
      tick;
    end
    inst_req = 0; data_req = 0; arready = 0;
    beat(4'd0, 32'hA1); beat(4'd1, 32'hB1); beat(4'd0, 32'hA2); beat(4'd1, 32'hB2);
    sample;
    chk("t2_drain", {dut.cnt0, dut.cnt1}, 0);
    tick;
    // AR stall holds the register; handover with no idle cycle
    data_req = 1; data_addr = 32'h00002000; data_size = 1;
    sample;
    chk("t3_data_ok", data_addr_ok, 1);
    ar_q.push_back({4'd1, 32'h00002000, 3'd1});
    tick;
    data_req = 0; inst_req = 1; inst_addr = 32'h00003000; inst_size = 0;
    for (int k = 0; k < 5; k++) begin
      sample;
      chk($sformatf("t3_hold%0d", k), {arvalid, arid, araddr, arsize, inst_addr_ok},
          {1'b1, 4'd1, 32'h00002000, 3'd1, 1'b0});
      tick;
    end
    arready = 1;
    sample;
    chk("t3_inst_ok", inst_addr_ok, 1);
    ar_q.push_back({4'd0, 32'h00003000, 3'd0});
    tick;
    inst_req = 0;
    sample;
    chk("t3_b2b", {arvalid, arid}, {1'b1, 4'd0});
    tick;
    arready = 0;
    sample;
    chk("t3_idle", arvalid, 0);
    tick;
    beat(4'd1, 32'hC1); beat(4'd0, 32'hC2);
    // read-after-write hazard
    arready = 1; wr_pend_valid = 1; wr_pend_addr = 32'h00001004;
    data_req = 1; data_addr = 32'h00001006; data_size = 2;
    for (int k = 0; k < 3; k++) begin
      inst_req = k == 1; inst_addr = 32'h00004000; inst_size = 2;
      sample;
      chk($sformatf("t4_stall%0d", k), {inst_addr_ok, data_addr_ok}, {k == 1, 1'b0});
      if (k == 1) ar_q.push_back({4'd0, 32'h00004000, 3'd2});
      tick;
    end
    inst_req = 0; wr_pend_valid = 0;
    sample;
    chk("t4_release", data_addr_ok, 1);
    ar_q.push_back({4'd1, 32'h00001006, 3'd2});
    tick;
    data_req = 0;
    tick;
    wr_pend_valid = 1; data_req = 1; data_addr = 32'h00001008;
    sample;
    chk("t4_other_word", data_addr_ok, 1);
    ar_q.push_back({4'd1, 32'h00001008, 3'd2});
    tick;
    data_req = 0; wr_pend_valid = 0;
    tick;
    arready = 0;
    beat(4'd0, 32'hD0); beat(4'd1, 32'hD1); beat(4'd1, 32'hD2);
    sample;
    chk("t4_drain", {dut.cnt0, dut.cnt1}, 0);
    tick;
    // unexpected R beats
    rvalid = 1; rid = 1; rdata = 32'hBAD;
    sample;
    chk("t5_no_ok", {inst_data_ok, data_data_ok}, 0);
    tick;
    rvalid = 0;
    sample;
    chk("t5_err", err_rid, 1);
    tick;
    rvalid = 1; rid = 2;
    sample;
    chk("t5_rid2_no_ok", {inst_data_ok, data_data_ok}, 0);
    tick;
    rvalid = 0;
    repeat (3) tick;
    sample;
    chk("t5_sticky", err_rid, 1);
    tick;
    // reset with reads outstanding
    arready = 1; inst_req = 1; inst_addr = 32'h00005000;
    sample;
    chk("t6_g0", inst_addr_ok, 1);
    ar_q.push_back({4'd0, 32'h00005000, 3'd2});
    tick;
    inst_addr = 32'h00005004;
    sample;
    chk("t6_g1", inst_addr_ok, 1);
    ar_q.push_back({4'd0, 32'h00005004, 3'd2});
    tick;
    inst_req = 0; arready = 0; aresetn = 0;
    tick;
    aresetn = 1;
    ar_q.delete();
    sample;
    chk("t6_after_rst", {arvalid, dut.cnt0, dut.cnt1, err_rid}, 0);
    tick;
    rvalid = 1; rid = 0; rdata = 32'h77;
    sample;
    chk("t6_late_no_ok", inst_data_ok, 0);
    tick;
    rvalid = 0;
    sample;
    chk("t6_late_err", err_rid, 1);
    chk("q_empty", {ar_q.size(), r_q.size()}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
